// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle crossing one pipeline-stage boundary.
// The stage itself uses the slave modport; the upstream/downstream environment uses master.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: main + skid entry with registered ready,
// synchronous flush to bubble, and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_stage_reg_if.slave  bus,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e              state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] m_data_q, s_data_q;
    logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic m_valid;
    logic accept;
    logic drain;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign m_valid = (state_q != EMPTY);
    assign accept  = bus.in_valid & in_ready_q;
    assign drain   = m_valid & bus.out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Ready is the registered image of "skid will be empty", so out_ready never reaches in_ready combinationally.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_q <= '0;
            m_ctrl_q <= '0;
            s_data_q <= '0;
            s_ctrl_q <= '0;
        end else begin
            if (load_main_in) begin
                m_data_q <= bus.in_data;
                m_ctrl_q <= bus.in_ctrl;
            end else if (load_main_skid) begin
                m_data_q <= s_data_q;
                m_ctrl_q <= s_ctrl_q;
            end
            if (load_skid) begin
                s_data_q <= bus.in_data;
                s_ctrl_q <= bus.in_ctrl;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (cnt_clr) begin
            stall_d = '0;
        end else if (m_valid && !bus.out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = m_valid;
    assign bus.out_data  = m_data_q;
    assign bus.out_ctrl  = m_valid ? m_ctrl_q : '0;
    assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, hand sequences,
// and randomised handshake against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 24;
    localparam int NW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          cnt_clr;
    logic [NW-1:0] stall_cnt;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t          mq[$];
    int unsigned   cnt_m;
    bit            last_acc;

    typedef struct {
        bit            iv;
        logic [DW-1:0] d;
        bit            ordy;
        bit            fl;
        bit            clr;
        bit            e_ov;
        logic [DW-1:0] e_d;
        logic [CW-1:0] e_c;
        bit            e_ir;
        logic [NW-1:0] e_st;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
        return d[CW-1:0] + 24'h100;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        bit mv;
        mv = (mq.size() > 0);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mv));
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(mq.size() < 2));
        if (mv) chk({tag, ".out_data"}, bus.out_data, mq[0].d);
        chk({tag, ".out_ctrl"}, 32'(bus.out_ctrl), mv ? 32'(mq[0].c) : 32'd0);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), cnt_m);
        chk({tag, ".legal_state"}, 32'(bus.out_valid | bus.in_ready), 32'd1);
    endtask

    // Advance one clock; the model consumes the pre-edge inputs and occupancy.
    task automatic cycle(input bit use_model);
        bit acc, drn;
        if (use_model) begin
            acc = bus.in_valid && (mq.size() < 2);
            drn = (mq.size() > 0) && bus.out_ready;
            if (cnt_clr) cnt_m = 0;
            else if ((mq.size() > 0) && !bus.out_ready && cnt_m != (1 << NW) - 1) cnt_m++;
            if (flush) begin
                mq.delete();
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back('{bus.in_data, bus.in_ctrl});
            end
            last_acc = acc && !flush;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit iv, input logic [DW-1:0] d, input bit ordy);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_ctrl   = ctrl_of(d);
        bus.out_ready = ordy;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        flush   = 1'b0;
        cnt_clr = 1'b0;
        set_in(1'b0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset.out_data", bus.out_data, 32'd0);
        chk("reset.out_ctrl", 32'(bus.out_ctrl), 32'd0);
        chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;
        mq.delete();
        cnt_m    = 0;
        last_acc = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        tbl[0]  = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b0, 1'b1, 32'hA,  24'h10A, 1'b1, 4'd0};
        tbl[1]  = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b0, 1'b1, 32'hA,  24'h10A, 1'b0, 4'd1};
        tbl[2]  = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b0, 1'b1, 32'hA,  24'h10A, 1'b0, 4'd2};
        tbl[3]  = '{1'b1, 32'hC,  1'b1, 1'b0, 1'b0, 1'b1, 32'hB,  24'h10B, 1'b1, 4'd2};
        tbl[4]  = '{1'b1, 32'hC,  1'b1, 1'b0, 1'b0, 1'b1, 32'hC,  24'h10C, 1'b1, 4'd2};
        tbl[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  24'h0,   1'b1, 4'd2};
        tbl[6]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 24'h111, 1'b1, 4'd2};
        tbl[7]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 24'h111, 1'b0, 4'd3};
        tbl[8]  = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  24'h0,   1'b1, 4'd4};
        tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  24'h0,   1'b1, 4'd4};
        tbl[10] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  24'h0,   1'b1, 4'd0};

        // Directed table: backpressure fill/drain, flush from TWO, counter clear.
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].iv, tbl[i].d, tbl[i].ordy);
            flush   = tbl[i].fl;
            cnt_clr = tbl[i].clr;
            cycle(1'b0);
            chk($sformatf("tbl%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) chk($sformatf("tbl%0d.out_data", i), bus.out_data, tbl[i].e_d);
            chk($sformatf("tbl%0d.out_ctrl", i), 32'(bus.out_ctrl), 32'(tbl[i].e_c));
            chk($sformatf("tbl%0d.in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d.stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].e_st));
        end
        flush   = 1'b0;
        cnt_clr = 1'b0;

        // Reset then stream 0..9 at full rate.
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'(i), 1'b1);
            cycle(1'b1);
            chk_model($sformatf("stream%0d", i));
            chk($sformatf("stream%0d.data", i), bus.out_data, 32'(i));
        end
        set_in(1'b0, '0, 1'b1);
        cycle(1'b1);
        chk_model("stream_end");

        // Stall counter saturation and clear-over-increment.
        set_in(1'b1, 32'h5, 1'b0);
        cycle(1'b1);
        set_in(1'b0, '0, 1'b0);
        repeat (20) cycle(1'b1);
        chk("sat.stall_cnt", 32'(stall_cnt), 32'd15);
        cnt_clr = 1'b1;
        cycle(1'b1);
        chk("clr.stall_cnt", 32'(stall_cnt), 32'd0);
        cnt_clr = 1'b0;
        cycle(1'b1);
        chk_model("after_clr");

        // Async reset between edges while in TWO.
        set_in(1'b1, 32'h6, 1'b0);
        cycle(1'b1);
        set_in(1'b0, '0, 1'b0);
        chk_model("pre_async");
        chk("pre_async.in_ready_low", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.out_valid", 32'(bus.out_valid), 32'd0);
        chk("async.in_ready", 32'(bus.in_ready), 32'd1);
        chk("async.stall_cnt", 32'(stall_cnt), 32'd0);
        chk("async.out_ctrl", 32'(bus.out_ctrl), 32'd0);
        apply_reset();

        // Randomised handshake against the queue model.
        for (int n = 0; n < 10000; n++) begin
            if (!(bus.in_valid && !last_acc)) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_data  = $urandom;
                bus.in_ctrl  = CW'($urandom);
            end
            bus.out_ready = ((n / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                 : ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 99) == 0);
            cnt_clr = ($urandom_range(0, 299) == 0);
            cycle(1'b1);
            chk_model("rand");
        end
        flush   = 1'b0;
        cnt_clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register, the successor to the fixed-width write-enable stage registers between pipeline stages. It carries a datapath bundle and a control bundle across one stage boundary with a valid/ready handshake. It has a two-entry skid buffer, so the ready path is fully registered, and a synchronous flush that converts in-flight entries into bubbles. It also keeps a saturating stall-cycle counter for performance analysis. One instance is placed at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- DATA_W, 32, width of datapath bundle (PC+4, operands, immediate, concatenated by the instantiator)
- CTRL_W, 24, width of control bundle (ALU/EX/MEM/WB control fields)
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, asynchronous assert, active-low (fixed)
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; equals "skid entry empty", driven from a flop
- in_data  in  DATA_W  upstream datapath bundle
- in_ctrl  in  CTRL_W  upstream control bundle
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head-entry datapath bundle
- out_ctrl  out  CTRL_W  head-entry control bundle; forced to 0 whenever out_valid=0 (bubble)
- flush  in  1  synchronous kill of all held entries and of the same-cycle input
- cnt_clr  in  1  synchronous clear of stall_cnt
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Storage: main entry {m_valid, m_data, m_ctrl} drives the outputs; skid entry {s_valid, s_data, s_ctrl}.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- States (occupancy): EMPTY (m_valid=0, s_valid=0), ONE (m_valid=1, s_valid=0), TWO (m_valid=1, s_valid=1). The state m_valid=0, s_valid=1 is illegal and must never occur.
- EMPTY: accept -> ONE, main <= input.
- ONE:
  - accept & drain -> ONE, main <= input.
  - accept & !drain -> TWO, skid <= input.
  - !accept & drain -> EMPTY.
  - otherwise hold.
- TWO (in_ready=0, so no accept): drain -> ONE, main <= skid; otherwise hold.
- flush=1 has highest priority:
  - next state EMPTY; the same-cycle input is discarded even if in_valid=1.
  - in_ready during the flush cycle follows s_valid as normal; it is 1 on the following cycle.
  - data registers need not clear; out_ctrl masking guarantees a bubble.
- Ordering is strictly FIFO; no entry is duplicated or lost except by flush.
- stall_cnt:
  - cnt_clr=1 -> 0, with priority over increment.
  - else if out_valid & !out_ready & stall_cnt != all-ones -> +1.
  - it holds at 2^CNT_W-1 (saturates, never wraps).
  - the counter is not affected by flush.
- Data and ctrl registers load only on their load conditions; there is no free-running capture.

## Timing
- Reset values (asynchronous, while rst_n=0): m_valid=0, s_valid=0, out_valid=0, in_ready=1, out_data=0, out_ctrl=0, stall_cnt=0.
- Latency: an input accepted at edge N appears on out_* from edge N (visible in cycle N+1) when EMPTY, or when ONE with same-cycle drain.
- Throughput is 1 entry/cycle sustained with out_ready=1.
- in_ready depends only on registered state; no combinational path from out_ready to in_ready.
- Combinational outputs: out_valid = m_valid; out_ctrl = m_valid ? m_ctrl : 0.
- A producer keeps in_valid/in_data/in_ctrl stable until accept; the block imposes the same on itself for out_*.
- Reset asserted mid-transfer: all entries are dropped immediately and asynchronously. Release is synchronous to the next edge; the first accept is possible at the first edge after release.

## Test plan
- Reset then stream: rst_n low 3 cycles, then in_valid=1 with in_data=0..9 and out_ready=1 -> out_data 0..9 on consecutive cycles, one cycle behind input; in_ready stays 1; stall_cnt=0.
- Backpressure fill: out_ready=0, push 0xA then 0xB -> state TWO, in_ready=0 on the cycle after the second accept, 0xC held off. Then out_ready=1 -> 0xA, 0xB, 0xC in order, none lost.
- Flush: TWO holding 0x11/0x22, flush=1 with in_valid=1 carrying 0x33 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x33 never appears.
- Stall counter: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds. cnt_clr and increment in the same cycle -> 0.
- Randomised handshake: random in_valid/out_ready for 10k cycles against a scoreboard -> exact in-order match. The illegal state (m_valid=0, s_valid=1) never occurs.
- Async reset mid-operation: assert rst_n low between edges while in TWO -> out_valid=0, in_ready=1, stall_cnt=0 immediately without waiting for a clock edge.
